// File: rtl/seq_multiplier_pkg.sv
// Shared definitions for the sequential multiplier: controller state encoding
// and the legal operand-width range.
package mult_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int MULT_MIN_WIDTH = 2;
    localparam int MULT_MAX_WIDTH = 32;

endpackage

// File: rtl/seq_multiplier_if.sv
// start/done handshake bundle for seq_multiplier; the signed_mode wire exists
// only when SEQ_MULT_SIGNED_EN is defined.
interface seq_multiplier_if #(
    parameter int WIDTH = 8
);
    logic               start;
    logic [WIDTH-1:0]   a;
    logic [WIDTH-1:0]   b;
    logic               ready;
    logic               busy;
    logic               done;
    logic [2*WIDTH-1:0] product;
`ifdef SEQ_MULT_SIGNED_EN
    logic               signed_mode;
`endif

    modport master (
        output start, a, b,
`ifdef SEQ_MULT_SIGNED_EN
        output signed_mode,
`endif
        input  ready, busy, done, product
    );

    modport slave (
        input  start, a, b,
`ifdef SEQ_MULT_SIGNED_EN
        input  signed_mode,
`endif
        output ready, busy, done, product
    );

endinterface

// File: rtl/seq_multiplier_add_sub_n.sv
// WIDTH-bit adder/subtractor with a WIDTH+1-bit result; operands are sign- or
// zero-extended by one bit so the result never overflows.
module add_sub_n
    import mult_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  logic             sgn,
    input  logic             sub,
    output logic [WIDTH:0]   sum
);
    logic signed [WIDTH:0] x_e;
    logic signed [WIDTH:0] y_e;

    always_comb begin
        x_e = {sgn & x[WIDTH-1], x};
        y_e = {sgn & y[WIDTH-1], y};
        sum = x_e + (y_e ^ {(WIDTH+1){sub}}) + {{WIDTH{1'b0}}, sub};
    end

endmodule

// File: rtl/seq_multiplier.sv
// Shift-add sequential multiplier: WIDTH iterations through one shared adder.
// Defining SEQ_MULT_SIGNED_EN adds two's-complement operation via signed_mode.
module seq_multiplier
    import mult_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    seq_multiplier_if.slave bus
);
    localparam int CNT_W = $clog2(WIDTH) + 1;

    if (WIDTH < MULT_MIN_WIDTH || WIDTH > MULT_MAX_WIDTH) begin : g_width_chk
        $error("seq_multiplier: WIDTH out of range");
    end

    state_t             state;
    logic [WIDTH-1:0]   hi;
    logic [WIDTH-1:0]   lo;
    logic [WIDTH-1:0]   a_q;
    logic [CNT_W-1:0]   cnt;
    logic [2*WIDTH-1:0] product_q;
    logic               done_q;
    logic               last;
    logic [WIDTH-1:0]   addend;
    logic [WIDTH:0]     sum;
    logic               sgn_op;
    logic               sub_op;

    assign last   = (cnt == CNT_W'(WIDTH - 1));
    assign addend = lo[0] ? a_q : '0;

`ifdef SEQ_MULT_SIGNED_EN
    logic sm_q;
    // The top multiplier bit carries negative weight, so it is subtracted.
    assign sgn_op = sm_q;
    assign sub_op = sm_q & last & lo[0];
`else
    assign sgn_op = 1'b0;
    assign sub_op = 1'b0;
`endif

    add_sub_n #(.WIDTH(WIDTH)) u_add_sub (
        .x   (hi),
        .y   (addend),
        .sgn (sgn_op),
        .sub (sub_op),
        .sum (sum)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            hi        <= '0;
            lo        <= '0;
            a_q       <= '0;
            cnt       <= '0;
            product_q <= '0;
            done_q    <= 1'b0;
`ifdef SEQ_MULT_SIGNED_EN
            sm_q      <= 1'b0;
`endif
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    if (state == DONE) begin
                        product_q <= {hi, lo};
                        done_q    <= 1'b1;
                    end
                    if (bus.start) begin
                        hi    <= '0;
                        lo    <= bus.b;
                        a_q   <= bus.a;
                        cnt   <= '0;
`ifdef SEQ_MULT_SIGNED_EN
                        sm_q  <= bus.signed_mode;
`endif
                        state <= RUN;
                    end else begin
                        state <= IDLE;
                    end
                end
                RUN: begin
                    // {sum, lo} shifted right by one; sum[WIDTH] is carry or sign.
                    hi  <= sum[WIDTH:1];
                    lo  <= {sum[0], lo[WIDTH-1:1]};
                    cnt <= cnt + 1'b1;
                    if (last) begin
                        state <= DONE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.ready   = (state == IDLE) || (state == DONE);
    assign bus.busy    = (state == RUN);
    assign bus.done    = done_q;
    assign bus.product = product_q;

endmodule

// File: tb/tb_seq_multiplier.sv
// Scoreboard bench for seq_multiplier (WIDTH=8): directed vectors push expected
// products and accept cycles; a monitor checks each done pulse against them.
module tb_seq_multiplier;
    localparam int W   = 8;
    localparam int LAT = W + 1;

    logic clk;
    logic rst_n;
    int   cyc;
    int   checks;
    int   errors;

    logic [2*W-1:0] exp_q[$];
    int             acc_q[$];

    seq_multiplier_if #(.WIDTH(W)) bus ();

    seq_multiplier #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        cyc = 0;
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    // Monitor: every done pulse must match the oldest outstanding request.
    initial begin
        logic           done_prev;
        logic [2*W-1:0] e;
        int             t;
        done_prev = 1'b0;
        forever begin
            @(negedge clk);
            if (bus.done) begin
                checks++;
                if (done_prev) begin
                    errors++;
                    $display("FAIL done_width: done high on consecutive cycles at cycle %0d", cyc);
                end
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_done: product=%h with nothing outstanding", bus.product);
                end else begin
                    e = exp_q.pop_front();
                    t = acc_q.pop_front();
                    checks++;
                    if (bus.product !== e) begin
                        errors++;
                        $display("FAIL product: got %h expected %h", bus.product, e);
                    end
                    checks++;
                    if (cyc - t != LAT) begin
                        errors++;
                        $display("FAIL latency: got %0d expected %0d", cyc - t, LAT);
                    end
                end
            end
            done_prev = bus.done;
        end
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, want);
        end
    endtask

    task automatic wait_ready();
        int n;
        n = 0;
        while (!bus.ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!bus.ready) begin
            checks++;
            errors++;
            $display("FAIL ready_timeout: ready=%b expected 1", bus.ready);
        end
    endtask

    task automatic issue(input logic [W-1:0] aa, input logic [W-1:0] bb,
                         input logic sm, input logic [2*W-1:0] exp, input bit expect_done);
        @(negedge clk);
        wait_ready();
        bus.start = 1'b1;
        bus.a     = aa;
        bus.b     = bb;
`ifdef SEQ_MULT_SIGNED_EN
        bus.signed_mode = sm;
`endif
        if (expect_done) begin
            exp_q.push_back(exp);
            acc_q.push_back(cyc + 1);
        end
        @(negedge clk);
        bus.start = 1'b0;
        check("busy_after_start", {31'd0, bus.busy}, 32'd1);
    endtask

    initial begin
        int n;
        logic sm_unused;
        checks    = 0;
        errors    = 0;
        sm_unused = 1'b0;
        rst_n     = 1'b0;
        bus.start = 1'b0;
        bus.a     = '0;
        bus.b     = '0;
`ifdef SEQ_MULT_SIGNED_EN
        bus.signed_mode = 1'b0;
`endif
        repeat (3) @(negedge clk);
        check("reset_product", {16'd0, bus.product}, 32'd0);
        check("reset_done",    {31'd0, bus.done},    32'd0);
        check("reset_ready",   {31'd0, bus.ready},   32'd1);
        check("reset_busy",    {31'd0, bus.busy},    32'd0);
        rst_n = 1'b1;

        issue(8'd15,  8'd13,  sm_unused, 16'h00C3, 1'b1);
        issue(8'd255, 8'd255, sm_unused, 16'hFE01, 1'b1);
        issue(8'd0,   8'hA5,  sm_unused, 16'h0000, 1'b1);
        issue(8'd1,   8'd255, sm_unused, 16'h00FF, 1'b1);

        // Back-to-back with start held high throughout.
        @(negedge clk);
        wait_ready();
        bus.start = 1'b1;
        bus.a = 8'd3;
        bus.b = 8'd4;
        exp_q.push_back(16'd12);
        acc_q.push_back(cyc + 1);
        @(negedge clk);
        wait_ready();
        bus.a = 8'd7;
        bus.b = 8'd9;
        exp_q.push_back(16'd63);
        acc_q.push_back(cyc + 1);
        @(negedge clk);
        wait_ready();
        bus.start = 1'b0;

        // Operand change and a stray start while running must be ignored.
        issue(8'd200, 8'd100, sm_unused, 16'h4E20, 1'b1);
        repeat (2) @(negedge clk);
        bus.a     = 8'd1;
        bus.b     = 8'd1;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;

        // Abort at iteration 4: no result, product cleared.
        issue(8'd10, 8'd10, sm_unused, 16'd0, 1'b0);
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check("abort_product", {16'd0, bus.product}, 32'd0);
        check("abort_ready",   {31'd0, bus.ready},   32'd1);
        check("abort_busy",    {31'd0, bus.busy},    32'd0);
        check("abort_done",    {31'd0, bus.done},    32'd0);
        rst_n = 1'b1;
        issue(8'd2, 8'd3, sm_unused, 16'd6, 1'b1);

`ifdef SEQ_MULT_SIGNED_EN
        issue(8'hFD, 8'h05, 1'b1, 16'hFFF1, 1'b1);
        issue(8'h80, 8'h80, 1'b1, 16'h4000, 1'b1);
        issue(8'hFD, 8'h05, 1'b0, 16'h04F1, 1'b1);
`endif

        n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d results outstanding expected 0", exp_q.size());
        end
        repeat (12) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

endmodule

// File: doc/seq_multiplier.md
# seq_multiplier

Parametrised sequential shift-add multiplier and the next generation of the team's combinational 4x4 array multiplier. It computes a WIDTH x WIDTH product over WIDTH iteration cycles using a single shared WIDTH-bit adder. This trades latency for area so wide multiplies fit in datapath blocks that cannot afford an N² array. It uses a start/done handshake to sit beside the existing adder and multiplier blocks in the arithmetic datapath.

## Interface
Parameters:
- WIDTH, default 8: operand width; legal range 2..32; product is 2*WIDTH bits.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst_n  input  1  reset, synchronous, active-low.
- start  input  1  request; sampled only when ready=1.
- a  input  WIDTH  multiplicand; captured with an accepted start.
- b  input  WIDTH  multiplier; captured with an accepted start.
- ready  output  1  high in IDLE and DONE; start is accepted only then.
- busy  output  1  high in RUN.
- done  output  1  one-cycle pulse; product is valid.
- product  output  2*WIDTH  result register; holds until the next result.
- signed_mode  input  1  present only with SEQ_MULT_SIGNED_EN; captured with start.

## Operation
- State machine IDLE -> RUN -> DONE:
  - IDLE: on start=1, load the accumulator as hi=0, lo=b, and latch a. Clear the counter. Go to RUN.
  - RUN: run one iteration per cycle for WIDTH cycles. Go to DONE after iteration WIDTH-1.
  - DONE: product <= accumulator and done=1. On start=1, reload and go to RUN (back-to-back); otherwise go to IDLE.
- Iteration (unsigned):
  - If lo[0]=1, form sum = hi + a as WIDTH+1 bits; otherwise sum = {0, hi}.
  - Shift {sum, lo} right by one into {hi, lo}.
- Counter width is $clog2(WIDTH)+1.
- start is ignored in RUN. Operand changes during RUN have no effect.
- ready and busy are combinational decodes of the state. done and product are registered.
- Reset values: state IDLE, product 0, done 0, busy 0, ready 1, accumulator 0, counter 0.
- Reset mid-RUN aborts the operation. No done pulse is issued and product returns to 0.
- If start and reset are asserted together, reset wins.

## Timing
- Latency: start accepted at edge t. done=1 and product is valid in the cycle following edge t+WIDTH+1.
  - Example: WIDTH=8 gives done 9 cycles after the accepting edge.
- Throughput with back-to-back start held high: one result every WIDTH+1 cycles.
- done is high for exactly one cycle per accepted start.
- product stays stable from done until the DONE state of the next operation.

## Configuration
- SEQ_MULT_SIGNED_EN defined:
  - The signed_mode port exists.
  - When signed_mode=1, operands are two's complement and hi+a is sign-extended to WIDTH+1 bits.
  - On the final iteration, if lo[0]=1 the adder subtracts: hi - a.
  - The shift is arithmetic.
  - When signed_mode=0, behaviour is identical to the unsigned build.
- SEQ_MULT_SIGNED_EN undefined: no signed_mode port; the block is unsigned only and the adder never subtracts.

## Structure
- Shared package mult_pkg holds:
  - the state enum (IDLE, RUN, DONE);
  - the width-range check constants MULT_MIN_WIDTH=2 and MULT_MAX_WIDTH=32.
- Sub-module add_sub_n (parameter WIDTH): a WIDTH-bit adder/subtractor with sub control and WIDTH+1-bit result. It is the only arithmetic instance in the block.
- Elaboration fails if WIDTH is out of range.

## Test plan
- WIDTH=8, a=15, b=13, start pulse -> done exactly 9 cycles after the accepting edge, product=0x00C3, done high one cycle.
- WIDTH=8, a=255, b=255 -> product=0xFE01. Then a=0, b=0xA5 -> product=0x0000.
- start held high continuously with a=3/b=4 then a=7/b=9 -> done pulses 9 cycles apart, products 12 then 63. start pulses during RUN are ignored.
- Operands changed to a=1, b=1 mid-RUN after a=200, b=100 -> product=0x4E20 (20000).
- rst_n=0 for one cycle at iteration 4 of a=10, b=10 -> no done, product=0, ready=1. The next start with a=2, b=3 -> product=6.
- SEQ_MULT_SIGNED_EN, signed_mode=1:
  - a=0xFD (-3), b=0x05 -> product=0xFFF1.
  - a=0x80, b=0x80 -> 0x4000.
  - signed_mode=0, a=0xFD, b=0x05 -> 0x04F1.
